sort_result_streamer: RTL and testbench

//  Consumer end of the bubbleSort output interface. Captures the sorted parallel vector on a

---
 rtl/sort_pkg.sv | 22 ++
 rtl/sort_order_checker.sv | 53 +++++
 rtl/sort_result_streamer.sv | 169 ++++++++++++++++
 tb/tb_sort_result_streamer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sort_pkg
//  Brief    : Shared defaults and FSM state encoding for the bubbleSort
//             result streamer.
//  Revision : 1.0 - initial release
// ============================================================================
package sort_pkg;

  // Default frame geometry of the upstream sort core
  localparam int c_SIZE_DATA_DEF = 8;
  localparam int c_NUM_VALS_DEF  = 8;

  // Streamer control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage : sort_pkg
`default_nettype wire

// File: rtl/sort_order_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sort_order_checker
//  Brief    : Watches accepted stream elements and raises a sticky error when
//             an element is smaller than the one accepted before it within
//             the same frame. Equal neighbours are legal.
//  Revision : 1.0 - initial release
// ============================================================================
module sort_order_checker
  import sort_pkg::*;
#(
  parameter int SIZE_DATA = c_SIZE_DATA_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_handshake,
  input  logic                 i_first,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_clr,
  output logic                 o_sort_err
);

  logic [SIZE_DATA-1:0] r_prev;
  logic                 r_sort_err;
  logic                 w_descent;

  // The first element of a frame has no predecessor, so it never flags
  assign w_descent = i_handshake & ~i_first & (i_data < r_prev);

  // Remember the most recently accepted element
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= '0;
    end else if (i_handshake) begin
      r_prev <= i_data;
    end
  end

  // Sticky order error; cleared only when a new frame is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sort_err <= 1'b0;
    end else if (i_clr) begin
      r_sort_err <= 1'b0;
    end else if (w_descent) begin
      r_sort_err <= 1'b1;
    end
  end

  assign o_sort_err = r_sort_err;

endmodule : sort_order_checker
`default_nettype wire

// File: rtl/sort_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : sort_result_streamer
//  Brief    : Captures the sorted vector on a rising edge of the sorter done
//             flag and drains it as a valid/ready stream, index 0 first.
//             Reports frame completion, ordering errors and overruns.
//  Revision : 1.0 - initial release
// ============================================================================
module sort_result_streamer
  import sort_pkg::*;
#(
  parameter int SIZE_DATA = c_SIZE_DATA_DEF,
  parameter int NUM_VALS  = c_NUM_VALS_DEF,
  // Derived; kept as a parameter so it can size the index port
  parameter int IDX_W     = $clog2(NUM_VALS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_done,
  input  logic [NUM_VALS*SIZE_DATA-1:0] i_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [SIZE_DATA-1:0]          o_data,
  output logic [IDX_W-1:0]              o_index,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic                          o_sort_err,
  output logic                          o_overrun
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_VALS - 1);

  logic [1:0]                          r_rst_sync;
  logic                                w_rst;
  logic                                r_done_q;
  logic                                w_done_rise;
  logic                                w_accept;
  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [NUM_VALS-1:0][SIZE_DATA-1:0]  r_buf;
  logic [IDX_W-1:0]                    r_index;
  logic                                r_overrun;
  logic                                w_valid;
  logic                                w_busy;
  logic                                w_frame_done;
  logic                                w_handshake;
  logic                                w_is_last;
  logic [SIZE_DATA-1:0]                w_cur_data;

  // Reset asserts immediately and releases two clocks after i_rst drops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_rst = r_rst_sync[1];

  // Delayed copy of done for rising-edge detection; a held level never retriggers
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= i_done;
    end
  end

  assign w_done_rise = i_done & ~r_done_q;
  // Only an edge seen while idle starts a frame; any other edge is an overrun
  assign w_accept    = w_done_rise & (r_state == ST_IDLE);

  assign w_is_last   = (r_index == c_LAST_IDX);
  assign w_handshake = w_valid & i_ready;
  assign w_cur_data  = r_buf[r_index];

  // FSM state register
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_done_rise)              w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_handshake && w_is_last) w_state_nxt = ST_DONE;
      ST_DONE:                                 w_state_nxt = ST_IDLE;
      default:                                 w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state only, so i_ready never reaches o_valid
  always_comb begin
    w_valid      = 1'b0;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_STREAM: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
      end
      ST_DONE: begin
        w_frame_done = 1'b1;
      end
      default: begin
        w_valid      = 1'b0;
      end
    endcase
  end

  // Frame buffer: sampled only when a new frame is accepted
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_buf <= '0;
    end else if (w_accept) begin
      r_buf <= i_data;
    end
  end

  // Element index: restarts per frame, advances on each non-final handshake
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_index <= '0;
    end else if (w_accept) begin
      r_index <= '0;
    end else if (w_handshake && !w_is_last) begin
      r_index <= r_index + 1'b1;
    end
  end

  // Sticky overrun on a done edge that arrives while a frame is still held
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_overrun <= 1'b0;
    end else if (w_done_rise && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  sort_order_checker #(
    .SIZE_DATA (SIZE_DATA)
  ) u_order_checker (
    .i_clk       (i_clk),
    .i_rst       (w_rst),
    .i_handshake (w_handshake),
    .i_first     (r_index == '0),
    .i_data      (w_cur_data),
    .i_clr       (w_accept),
    .o_sort_err  (o_sort_err)
  );

  // Element fields are zeroed outside streaming so idle outputs are quiet
  assign o_valid      = w_valid;
  assign o_data       = w_valid ? w_cur_data : '0;
  assign o_index      = w_valid ? r_index : '0;
  assign o_last       = w_valid & w_is_last;
  assign o_busy       = w_busy;
  assign o_frame_done = w_frame_done;
  assign o_overrun    = r_overrun;

endmodule : sort_result_streamer
`default_nettype wire

// File: tb/tb_sort_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sort_result_streamer
//  Brief    : Randomized self-checking bench for sort_result_streamer using a
//             queue-based frame model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sort_result_streamer;

  localparam int SD = 8;
  localparam int NV = 8;

  logic                  i_clk   = 1'b0;
  logic                  i_rst   = 1'b1;
  logic                  i_done  = 1'b0;
  logic                  i_ready = 1'b0;
  logic [NV-1:0][SD-1:0] i_data  = '0;
  logic                  o_valid;
  logic [SD-1:0]         o_data;
  logic [2:0]            o_index;
  logic                  o_last;
  logic                  o_busy;
  logic                  o_frame_done;
  logic                  o_sort_err;
  logic                  o_overrun;

  int checks  = 0;
  int errors  = 0;
  int rdy_pct = 100;

  sort_result_streamer #(
    .SIZE_DATA (SD),
    .NUM_VALS  (NV)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_done       (i_done),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_index      (o_index),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_sort_err   (o_sort_err),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sink readiness, re-randomized shortly after every rising edge
  always @(posedge i_clk) begin
    #2;
    i_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  // Reference model: queue of elements still to be streamed plus sticky flags
  byte unsigned m_q[$];
  bit           m_fd, m_err, m_ovr, m_done_prev;
  byte unsigned m_prev;

  always @(negedge i_clk) begin
    bit           idle, rise, nfd;
    int           pos;
    byte unsigned v;
    if (i_rst) begin
      m_q.delete();
      m_fd = 0; m_err = 0; m_ovr = 0; m_done_prev = 0; m_prev = 0;
    end
    chk("valid",      o_valid,      m_q.size() != 0);
    chk("busy",       o_busy,       m_q.size() != 0);
    chk("frame_done", o_frame_done, m_fd);
    chk("sort_err",   o_sort_err,   m_err);
    chk("overrun",    o_overrun,    m_ovr);
    if (m_q.size() != 0) begin
      chk("data",  o_data,  m_q[0]);
      chk("index", o_index, NV - m_q.size());
      chk("last",  o_last,  m_q.size() == 1);
    end
    if (!i_rst) begin
      idle        = (m_q.size() == 0) && !m_fd;
      rise        = i_done && !m_done_prev;
      m_done_prev = i_done;
      nfd         = 0;
      if (m_q.size() != 0 && i_ready) begin
        pos = NV - m_q.size();
        v   = m_q.pop_front();
        if (pos > 0 && v < m_prev) m_err = 1;
        m_prev = v;
        if (m_q.size() == 0) nfd = 1;
      end
      if (rise) begin
        if (idle) begin
          for (int i = 0; i < NV; i++) m_q.push_back(i_data[i]);
          m_err = 0;
        end else begin
          m_ovr = 1;
        end
      end
      m_fd = nfd;
    end
  end

  task automatic send(input logic [NV-1:0][SD-1:0] f);
    @(posedge i_clk); #2;
    i_data = f;
    i_done = 1'b1;
    @(posedge i_clk); #2;
    i_done = 1'b0;
    i_data = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_q.size() != 0 || m_fd) && n < 400) begin
      @(posedge i_clk);
      n++;
    end
    if (n >= 400) chk("timeout", 0, 1);
    repeat (2) @(posedge i_clk);
  endtask

  function automatic logic [NV-1:0][SD-1:0] rand_frame(input bit sorted, input bit dup);
    byte unsigned          a[NV];
    logic [NV-1:0][SD-1:0] f;
    for (int i = 0; i < NV; i++) a[i] = dup ? 8'd5 : 8'($urandom_range(0, 255));
    if (sorted) a.sort();
    for (int i = 0; i < NV; i++) f[i] = a[i];
    return f;
  endfunction

  function automatic logic [NV-1:0][SD-1:0] from_list(input int unsigned l[NV]);
    logic [NV-1:0][SD-1:0] f;
    for (int i = 0; i < NV; i++) f[i] = SD'(l[i]);
    return f;
  endfunction

  initial begin
    int unsigned l_sorted[NV]   = '{1, 2, 3, 4, 5, 6, 7, 8};
    int unsigned l_unsorted[NV] = '{1, 3, 2, 4, 5, 6, 7, 8};

    // Power-on reset
    repeat (3) @(posedge i_clk);
    #2 i_rst = 1'b0;
    repeat (5) @(posedge i_clk);

    // Sorted frame at full throughput
    rdy_pct = 100;
    send(from_list(l_sorted));
    wait_idle();
    chk("sorted_err", o_sort_err, 0);

    // Unsorted frame raises the error, next sorted frame clears it
    send(from_list(l_unsorted));
    wait_idle();
    chk("unsorted_err", o_sort_err, 1);
    send(from_list(l_sorted));
    wait_idle();
    chk("cleared_err", o_sort_err, 0);

    // Backpressure with random, sorted and duplicate frames
    rdy_pct = 50;
    send(rand_frame(1'b1, 1'b1));
    wait_idle();
    chk("dup_err", o_sort_err, 0);
    for (int k = 0; k < 8; k++) begin
      send(rand_frame(k[0], 1'b0));
      wait_idle();
    end

    // Overrun: second done edge mid-frame is dropped and flagged
    rdy_pct = 100;
    chk("ovr_before", o_overrun, 0);
    send(from_list(l_sorted));
    repeat (2) @(posedge i_clk);
    send(rand_frame(1'b0, 1'b0));
    wait_idle();
    chk("ovr_after", o_overrun, 1);

    // Level done: one frame only while held; a fresh rise gives another
    rdy_pct = 60;
    @(posedge i_clk); #2;
    i_data = rand_frame(1'b1, 1'b0);
    i_done = 1'b1;
    repeat (40) @(posedge i_clk);
    #2 i_done = 1'b0;
    wait_idle();
    send(rand_frame(1'b1, 1'b0));
    wait_idle();

    // Reset mid-stream forces every output low at once
    rdy_pct = 100;
    send(from_list(l_sorted));
    repeat (2) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_valid",  o_valid,      0);
    chk("rst_busy",   o_busy,       0);
    chk("rst_data",   o_data,       0);
    chk("rst_index",  o_index,      0);
    chk("rst_last",   o_last,       0);
    chk("rst_fdone",  o_frame_done, 0);
    chk("rst_err",    o_sort_err,   0);
    chk("rst_ovr",    o_overrun,    0);
    repeat (2) @(posedge i_clk);
    #2 i_rst = 1'b0;
    repeat (6) @(posedge i_clk);
    chk("post_rst_valid", o_valid, 0);

    // Streaming resumes normally after reset
    rdy_pct = 70;
    send(rand_frame(1'b1, 1'b0));
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sort_result_streamer
`default_nettype wire
